// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
//   Turns a byte-serial command stream from a UART receiver into single-cycle
//   bus operations for the downstream bus slave. It then returns the read data,
//   or a write acknowledge, through the UART transmitter.
//   Frame: cmd (0x01 READ / 0x02 WRITE), 8 address bytes LSB first, and for
//   WRITE 8 data bytes LSB first. Response: 8 read bytes LSB first, or 0x02.
//
// Ports
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_rx_data/_valid, o_rx_data_rdy       receive byte handshake
//   o_tx_data/_valid, i_tx_data_rdy       transmit byte handshake
//   o_mem_op/_addr/_data                  bus op (0 NOP, 1 READ, 2 WRITE)
//   i_mem_data, i_mem_op_pending          slave read data / read in progress
//   o_busy                                high outside the CMD state
//   o_cmd_err                             pulse on an unknown command byte
//   o_timeout                             pulse on inter-byte timeout
//
// Build option
//   UART_MEM_BRIDGE_TIMEOUT_EN : abort a partial command after TIMEOUT_CYCLES
//   idle cycles in ADDR/DATA. Without it o_timeout is tied 0.
module uart_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_data_valid,
  output logic        o_rx_data_rdy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_data_valid,
  input  logic        i_tx_data_rdy,
  output logic [1:0]  o_mem_op,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_data,
  input  logic [63:0] i_mem_data,
  input  logic        i_mem_op_pending,
  output logic        o_busy,
  output logic        o_cmd_err,
  output logic        o_timeout
);

  localparam logic [2:0] S_CMD   = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q;
  logic [2:0]  cnt_q;      // byte index shared by ADDR, DATA and RESP
  logic [63:0] addr_q, data_q, rdata_q;
  logic [7:0]  tx_data_q;
  logic        tx_vld_q;
  logic        cmd_err_q;
  logic        rx_fire, tx_fire, to_hit;

  assign o_rx_data_rdy = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_fire       = i_rx_data_valid && o_rx_data_rdy;
  assign tx_fire       = tx_vld_q && i_tx_data_rdy;

  // The slave samples op every cycle, so op is only non-NOP for ISSUE.
  assign o_mem_op        = (state_q == S_ISSUE) ? op_q : OP_NOP;
  assign o_mem_addr      = addr_q;
  assign o_mem_data      = data_q;
  assign o_tx_data       = tx_data_q;
  assign o_tx_data_valid = tx_vld_q;
  assign o_busy          = (state_q != S_CMD);
  assign o_cmd_err       = cmd_err_q;

`ifdef UART_MEM_BRIDGE_TIMEOUT_EN
  logic [15:0] idle_q;
  logic        timeout_q;

  assign to_hit = ((state_q == S_ADDR) || (state_q == S_DATA)) && !rx_fire &&
                  (idle_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if (((state_q == S_ADDR) || (state_q == S_DATA)) && !rx_fire && !to_hit)
        idle_q <= idle_q + 16'd1;
      else
        idle_q <= '0;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD:   if (rx_fire && (i_rx_data == 8'h01 || i_rx_data == 8'h02)) state_d = S_ADDR;
      S_ADDR:  if (rx_fire && cnt_q == 3'd7) state_d = (op_q == OP_WRITE) ? S_DATA : S_ISSUE;
      S_DATA:  if (rx_fire && cnt_q == 3'd7) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (!i_mem_op_pending) state_d = S_RESP;
      S_RESP:  if (tx_fire && (op_q == OP_WRITE || cnt_q == 3'd7)) state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
    if (to_hit) state_d = S_CMD;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_CMD;
      op_q      <= OP_NOP;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_err_q <= 1'b0;
      case (state_q)
        S_CMD: begin
          cnt_q <= '0;
          if (rx_fire) begin
            if (i_rx_data == 8'h01)      op_q <= OP_READ;
            else if (i_rx_data == 8'h02) op_q <= OP_WRITE;
            else                         cmd_err_q <= 1'b1;
          end
        end
        // Shift in from the top: after 8 bytes, byte k sits at [8k+7:8k].
        // The 3-bit counter wraps to 0 after byte 7, ready for the next phase.
        S_ADDR: if (rx_fire) begin
          addr_q <= {i_rx_data, addr_q[63:8]};
          cnt_q  <= cnt_q + 3'd1;
        end
        S_DATA: if (rx_fire) begin
          data_q <= {i_rx_data, data_q[63:8]};
          cnt_q  <= cnt_q + 3'd1;
        end
        S_WAIT: if (!i_mem_op_pending) begin
          cnt_q    <= '0;
          tx_vld_q <= 1'b1;
          if (op_q == OP_READ) begin
            rdata_q   <= i_mem_data;
            tx_data_q <= i_mem_data[7:0];
          end else begin
            tx_data_q <= 8'h02;
          end
        end
        // One idle cycle follows every transfer; the next byte is loaded then.
        S_RESP: begin
          if (tx_fire) begin
            tx_vld_q <= 1'b0;
            cnt_q    <= cnt_q + 3'd1;
            rdata_q  <= {8'h00, rdata_q[63:8]};
          end else if (!tx_vld_q) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= rdata_q[7:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
module tb_uart_mem_bridge;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_data_valid = 1'b0;
  logic        o_rx_data_rdy;
  logic [7:0]  o_tx_data;
  logic        o_tx_data_valid;
  logic        i_tx_data_rdy = 1'b0;
  logic [1:0]  o_mem_op;
  logic [63:0] o_mem_addr, o_mem_data;
  logic [63:0] i_mem_data = '0;
  logic        i_mem_op_pending = 1'b0;
  logic        o_busy, o_cmd_err, o_timeout;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // slave model / monitors
  int          cyc = 0;
  int          mem_lat = 0;
  logic [63:0] mem_rdata = '0;
  int          pend_left = 0;
  int          op_cycles = 0;
  int          issue_cyc = 0;
  logic [1:0]  last_op = '0;
  logic [63:0] last_addr = '0, last_data = '0;
  int          err_cnt = 0;
  int          to_cnt = 0;
  int          to_cyc = 0;

  always #5 i_clk = ~i_clk;

  uart_mem_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rx_data(i_rx_data), .i_rx_data_valid(i_rx_data_valid), .o_rx_data_rdy(o_rx_data_rdy),
    .o_tx_data(o_tx_data), .o_tx_data_valid(o_tx_data_valid), .i_tx_data_rdy(i_tx_data_rdy),
    .o_mem_op(o_mem_op), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data), .i_mem_op_pending(i_mem_op_pending),
    .o_busy(o_busy), .o_cmd_err(o_cmd_err), .o_timeout(o_timeout)
  );

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_mem_op != 2'd0) begin
      op_cycles <= op_cycles + 1;
      issue_cyc <= cyc;
      last_op   <= o_mem_op;
      last_addr <= o_mem_addr;
      last_data <= o_mem_data;
    end
    if (o_cmd_err) err_cnt <= err_cnt + 1;
    if (o_timeout) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  // Slave: after a READ, hold pending for mem_lat cycles, then return mem_rdata.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      pend_left        <= 0;
      i_mem_op_pending <= 1'b0;
    end else begin
      if (pend_left > 0) begin
        i_mem_op_pending <= 1'b1;
        pend_left        <= pend_left - 1;
      end else begin
        i_mem_op_pending <= 1'b0;
        i_mem_data       <= mem_rdata;
      end
      if (o_mem_op == 2'd1 && mem_lat > 0) begin
        pend_left  <= mem_lat;
        i_mem_data <= 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_rx_data       = b;
    i_rx_data_valid = 1'b1;
    while (!o_rx_data_rdy && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    checks++;
    if (!o_rx_data_rdy) begin
      failures++;
      $display("FAIL rx_accept: byte %02h never accepted (rdy=%b, required 1)", b, o_rx_data_rdy);
    end
    @(negedge i_clk);
    i_rx_data_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [63:0] addr,
                          input logic [63:0] data, input bit with_data);
    send_byte(cmd);
    for (int k = 0; k < 8; k++) send_byte(addr[8*k +: 8]);
    if (with_data)
      for (int k = 0; k < 8; k++) send_byte(data[8*k +: 8]);
  endtask

  // Collect n tx bytes, comparing each against the scoreboard. When stall_idx
  // is hit, hold tx ready low for 20 cycles and check the byte stays put.
  task automatic recv(input int n, input int stall_idx, output int first_cyc);
    int got = 0;
    int guard = 0;
    bit rx_rdy_seen = 1'b0;
    bit unstable = 1'b0;
    logic [7:0] held;
    logic [7:0] exp;
    first_cyc = -1;
    i_tx_data_rdy = 1'b1;
    while (got < n && guard < 2000) begin
      if (o_rx_data_rdy && o_busy && o_mem_op == 2'd0 && o_tx_data_valid) rx_rdy_seen = 1'b1;
      if (o_tx_data_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (got == stall_idx) begin
          i_tx_data_rdy = 1'b0;
          held = o_tx_data;
          repeat (20) begin
            @(negedge i_clk);
            if (o_tx_data !== held || o_tx_data_valid !== 1'b1) unstable = 1'b1;
            if (o_rx_data_rdy) rx_rdy_seen = 1'b1;
          end
          checks++;
          if (unstable) begin
            failures++;
            $display("FAIL tx_hold: byte changed during stall, now %02h valid=%b, required %02h valid=1",
                     o_tx_data, o_tx_data_valid, held);
          end
          i_tx_data_rdy = 1'b1;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        checks++;
        if (o_tx_data !== exp) begin
          failures++;
          $display("FAIL tx_byte[%0d]: got %02h, required %02h", got, o_tx_data, exp);
        end
        got++;
      end
      @(negedge i_clk);
      guard++;
    end
    i_tx_data_rdy = 1'b0;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL tx_count: got %0d bytes, required %0d", got, n);
    end
    checks++;
    if (rx_rdy_seen) begin
      failures++;
      $display("FAIL rx_rdy_in_resp: o_rx_data_rdy was 1, required 0");
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({o_mem_op, o_mem_addr, o_mem_data} !== 130'd0) begin
      failures++;
      $display("FAIL %s_bus: op=%0d addr=%h data=%h, required all 0", tag, o_mem_op, o_mem_addr, o_mem_data);
    end
    checks++;
    if (o_tx_data !== 8'h00 || o_tx_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_tx: data=%02h valid=%b, required 00/0", tag, o_tx_data, o_tx_data_valid);
    end
    checks++;
    if ({o_rx_data_rdy, o_busy, o_cmd_err, o_timeout} !== 4'b1000) begin
      failures++;
      $display("FAIL %s_ctl: rdy/busy/err/to=%b, required 1000", tag,
               {o_rx_data_rdy, o_busy, o_cmd_err, o_timeout});
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check_idle_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic check_op(input string tag, input int opc0, input logic [1:0] op,
                          input logic [63:0] addr, input logic [63:0] data, input bit chk_data);
    checks++;
    if (op_cycles - opc0 != 1) begin
      failures++;
      $display("FAIL %s_op_cycles: got %0d, required 1", tag, op_cycles - opc0);
    end
    checks++;
    if (last_op !== op || last_addr !== addr) begin
      failures++;
      $display("FAIL %s_op: op=%0d addr=%h, required op=%0d addr=%h", tag, last_op, last_addr, op, addr);
    end
    if (chk_data) begin
      checks++;
      if (last_data !== data) begin
        failures++;
        $display("FAIL %s_wdata: got %h, required %h", tag, last_data, data);
      end
    end
  endtask

  task automatic do_write(input string tag, input logic [63:0] addr, input logic [63:0] data);
    int opc0 = op_cycles;
    int fc;
    send_cmd(8'h02, addr, data, 1'b1);
    exp_q.push_back(8'h02);
    recv(1, -1, fc);
    check_op(tag, opc0, 2'd2, addr, data, 1'b1);
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: got %b after ack, required 0", tag, o_busy);
    end
  endtask

  task automatic do_read(input string tag, input logic [63:0] addr, input logic [63:0] rdata,
                         input int lat, input int stall_idx, input int exp_first);
    int opc0 = op_cycles;
    int fc;
    mem_lat   = lat;
    mem_rdata = rdata;
    send_cmd(8'h01, addr, 64'd0, 1'b0);
    for (int k = 0; k < 8; k++) exp_q.push_back(rdata[8*k +: 8]);
    recv(8, stall_idx, fc);
    check_op(tag, opc0, 2'd1, addr, 64'd0, 1'b0);
    checks++;
    if (fc - issue_cyc != exp_first) begin
      failures++;
      $display("FAIL %s_latency: first tx %0d cycles after issue, required %0d", tag, fc - issue_cyc, exp_first);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: got %b after response, required 0", tag, o_busy);
    end
  endtask

  task automatic test_write();
    do_write("write", 64'h10, 64'h1122334455667788);
  endtask

  task automatic test_mem_read();
    do_read("mem_read", 64'h10, 64'h1122334455667788, 2, -1, 4);
  endtask

  task automatic test_reg_read();
    do_read("reg_read", 64'h8000000000000001, 64'h1, 0, -1, 2);
  endtask

  task automatic test_bad_cmd();
    int e0 = err_cnt;
    int opc0 = op_cycles;
    send_byte(8'h7F);
    repeat (3) @(negedge i_clk);
    checks++;
    if (err_cnt - e0 != 1 || op_cycles != opc0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_cmd: err pulses=%0d ops=%0d busy=%b, required 1/0/0",
               err_cnt - e0, op_cycles - opc0, o_busy);
    end
    do_write("after_bad", 64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    checks++;
    if (err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL bad_cmd_err_total: got %0d pulses, required 1", err_cnt - e0);
    end
  endtask

  task automatic test_back_pressure();
    do_read("bp_read", 64'h20, 64'hA1B2C3D4E5F60718, 2, 3, 4);
  endtask

  task automatic test_timeout();
    int c0;
    int t0 = to_cnt;
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    c0 = cyc;
`ifdef UART_MEM_BRIDGE_TIMEOUT_EN
    repeat (30) @(negedge i_clk);
    checks++;
    if (to_cnt - t0 != 1 || to_cyc - c0 != 16) begin
      failures++;
      $display("FAIL timeout_pulse: pulses=%0d at +%0d cycles, required 1 at +16", to_cnt - t0, to_cyc - c0);
    end
    checks++;
    if (o_busy !== 1'b0 || o_rx_data_rdy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_state: busy=%b rdy=%b, required 0/1", o_busy, o_rx_data_rdy);
    end
    do_read("after_timeout", 64'h8000000000000040, 64'h55AA55AA12345678, 0, -1, 2);
`else
    repeat (40) @(negedge i_clk);
    checks++;
    if (to_cnt != t0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL no_timeout: pulses=%0d busy=%b (start cyc %0d), required 0/1", to_cnt - t0, o_busy, c0);
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
`endif
  endtask

  task automatic test_reset_mid();
    bit tx_seen = 1'b0;
    mem_lat   = 30;
    mem_rdata = 64'h0F0E0D0C0B0A0908;
    send_cmd(8'h01, 64'h30, 64'd0, 1'b0);
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b1 || i_mem_op_pending !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup: busy=%b pending=%b, required 1/1", o_busy, i_mem_op_pending);
    end
    i_tx_data_rdy = 1'b1;
    #2;
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    repeat (3) @(negedge i_clk);
    mem_lat = 0;
    i_rst_n = 1'b1;
    repeat (40) begin
      @(negedge i_clk);
      if (o_tx_data_valid) tx_seen = 1'b1;
    end
    i_tx_data_rdy = 1'b0;
    checks++;
    if (tx_seen || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abort: tx_seen=%b busy=%b, required 0/0", tx_seen, o_busy);
    end
    do_write("after_reset", 64'h40, 64'h0000_0000_DEAD_BEEF);
  endtask

  initial begin
    @(negedge i_clk);
    test_reset();
    test_write();
    test_mem_read();
    test_reg_read();
    test_bad_cmd();
    test_back_pressure();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d bytes, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

Host command bridge between the UART receive/transmit pair and the memory/register bus of the `top` bus slave. It parses a byte-serial command stream (read or write, 64-bit address, 64-bit data) from the UART receiver and issues a single-cycle bus operation. It waits out the slave's read latency, then streams read data or a write acknowledge back through the UART transmitter. It is the upstream master of the `top` bus: its `o_mem_*` outputs drive the slave's `i_mem_*` inputs directly.

## Interface
- `TIMEOUT_CYCLES`, 1024: inter-byte timeout in clock cycles. Used only with `UART_MEM_BRIDGE_TIMEOUT_EN`. Legal range 2..65535.
- `i_clk` input 1: single clock; all state updates on rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_rx_data` input 8: received byte.
- `i_rx_data_valid` input 1: receiver holds a byte.
- `o_rx_data_rdy` output 1: bridge accepts a byte. Transfer happens when `i_rx_data_valid && o_rx_data_rdy`.
- `o_tx_data` output 8: byte to transmit.
- `o_tx_data_valid` output 1: byte offered. Transfer happens when `o_tx_data_valid && i_tx_data_rdy`.
- `i_tx_data_rdy` input 1: transmitter can take a byte.
- `o_mem_op` output 2: bus op, 0 = NOP, 1 = READ, 2 = WRITE.
- `o_mem_addr` output 64: bus address; bit 63 set selects the register space.
- `o_mem_data` output 64: write data.
- `i_mem_data` input 64: slave read data.
- `i_mem_op_pending` input 1: slave read in progress.
- `o_busy` output 1: high in every state except CMD.
- `o_cmd_err` output 1: one-cycle pulse when an unknown command byte is received.
- `o_timeout` output 1: one-cycle pulse on inter-byte timeout. Tied 0 without the macro.

## Operation
- Command framing: cmd byte, then 8 address bytes (LSB first). For WRITE, 8 more data bytes follow (LSB first).
  - cmd 0x01 = READ.
  - cmd 0x02 = WRITE.
  - Any other cmd value: drop the byte, pulse `o_cmd_err`, stay in CMD.
- State machine and transitions:
  - CMD → ADDR on a valid cmd byte.
  - ADDR collects 8 bytes via a 3-bit counter. After byte 7: READ → ISSUE, WRITE → DATA.
  - DATA collects 8 bytes → ISSUE.
  - ISSUE: one cycle → WAIT.
  - WAIT → RESP on the first cycle with `i_mem_op_pending == 0`.
  - RESP → CMD after the last response byte transfers.
- Address and data are assembled by shift-in: each byte lands in bits [8k+7:8k] for byte index k.
- `o_mem_op` equals the latched command only in ISSUE and is NOP in every other state. The slave samples op every cycle, so any multi-cycle op would re-issue.
- `o_mem_addr` and `o_mem_data` hold stable from ISSUE through RESP.
- WAIT behaviour:
  - Never samples in the ISSUE cycle.
  - For READ, captures `i_mem_data` into a 64-bit shift register on exit.
  - For WRITE, ignores `i_mem_data`.
- RESP payload:
  - READ: 8 bytes, LSB first.
  - WRITE: single ack byte 0x02.
- `o_rx_data_rdy` is high only in CMD, ADDR and DATA. Bytes arriving during ISSUE, WAIT or RESP are back-pressured, never dropped.
- Reset values:
  - `o_mem_op` = 0, `o_mem_addr` = 0, `o_mem_data` = 0.
  - `o_tx_data` = 0, `o_tx_data_valid` = 0.
  - `o_rx_data_rdy` = 1, `o_busy` = 0, `o_cmd_err` = 0, `o_timeout` = 0.
  - State = CMD, all counters = 0.
- Reset asserted mid-transaction aborts immediately. No partial response is sent, and any half-received command is discarded.

## Timing
- Byte acceptance costs 1 cycle per byte when the receiver streams continuously.
- After the last payload byte's transfer edge, ISSUE is the next cycle.
- Register-space read (slave answers in 1 cycle, pending never high): ISSUE at N, WAIT sees pending = 0 at N+1 and captures, first TX byte is valid at N+2.
- Memory read (pending high at N+1 and N+2): capture happens at N+3, first TX byte is valid at N+4.
- TX back-pressure: `o_tx_data` and `o_tx_data_valid` stay stable while `i_tx_data_rdy` is low. The next byte is presented the cycle after a transfer, so `o_tx_data_valid` drops for one cycle between bytes.
- Simultaneous rx valid and tx activity cannot occur: `o_rx_data_rdy` is low in RESP.

## Configuration
- `UART_MEM_BRIDGE_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs in ADDR and DATA, and clears on each accepted byte.
  - On reaching `TIMEOUT_CYCLES`: return to CMD, discard the partial command, pulse `o_timeout` for one cycle.
  - CMD, ISSUE, WAIT and RESP never time out.
- Not defined: no counter is built, `o_timeout` is constant 0, and a partial command waits indefinitely.

## Test plan
- Write: rx 02, 10 00 00 00 00 00 00 00, 88 77 66 55 44 33 22 11 → exactly one cycle of `o_mem_op` = 2 with `o_mem_addr` = 0x10 and `o_mem_data` = 0x1122334455667788; tx 0x02; `o_busy` falls after the ack.
- Memory read: rx 01, 10 00 00 00 00 00 00 00; slave model holds pending for 2 cycles then returns 0x1122334455667788 → one READ cycle; tx 88 77 66 55 44 33 22 11 in order.
- Register read: rx 01, 01 00 00 00 00 00 00 80; pending never high; `i_mem_data` = 1 → `o_mem_addr` = 0x8000000000000001; tx 01 00 00 00 00 00 00 00; first tx valid 2 cycles after ISSUE.
- Bad command: rx 0x7F, then a valid write → `o_cmd_err` pulses once; no bus op for 0x7F; the write completes normally.
- Back-pressure: hold `i_tx_data_rdy` low for 20 cycles after the 3rd read-response byte → byte 4 held stable; no loss or reorder; `o_rx_data_rdy` = 0 throughout.
- Timeout and reset: with the macro defined and `TIMEOUT_CYCLES` = 16, rx 01 + 3 address bytes then idle → `o_timeout` pulses 16 cycles after the last byte and the bridge returns to CMD. Separately, assert `i_rst_n` = 0 during WAIT → all outputs at reset values asynchronously, no tx.
